conv_mac_acc16: RTL and testbench
=================================

Name: conv_mac_acc16

Overview:
- Streaming multiply-accumulate stage directly upstream of the 16-to-8-bit requantiser in the conv_v2 arithmetic path.
- Multiplies unsigned 8-bit activations by signed 8-bit weights and sums one kernel window of pKERNEL_LEN products onto a signed bias.
- Applies ReLU, saturates to 16-bit unsigned, and presents one odata word per window with a single-cycle ovalid strobe.

Parameters:
- pKERNEL_LEN, 9: products per window; legal range 2..1024.
- pCNT_W, $clog2(pKERNEL_LEN): width of the window position counter.
- pACC_W, 17+$clog2(pKERNEL_LEN)+1: signed accumulator width; guarantees no internal overflow.

Ports:
- iclk  in  1: clock, rising edge.
- irst  in  1: reset, asynchronous, active-high.
- ivalid  in  1: idata/iweight/ibias valid this cycle; gaps allowed.
- idata  in  8: unsigned activation.
- iweight  in  8: signed two's-complement weight.
- ibias  in  16: signed bias; sampled only with the first sample of a window.
- odata  out  16: unsigned ReLU-and-saturated window sum.
- ovalid  out  1: one-cycle strobe; odata is valid in this cycle.
- osat  out  1: qualified by ovalid; 1 when the positive sum exceeded 65535 and was clamped.
- ocount  out  pCNT_W: number of samples accepted in the current window (0..pKERNEL_LEN-1).

Behaviour:
- Reset values (asynchronous): odata=0, ovalid=0, osat=0, ocount=0, accumulator=0, all pipeline valid/last flags=0.
- Stage 1, on the edge where ivalid=1:
  - Register product p = $signed({1'b0,idata}) * $signed(iweight) as 17-bit signed.
  - Register a first flag (ocount==0), a last flag (ocount==pKERNEL_LEN-1), and the sign-extended ibias when first=1.
  - Increment ocount; wrap to 0 after pKERNEL_LEN-1.
- Stage 2, when the stage-1 valid flag is set:
  - first=1: acc <= bias + p.
  - Otherwise: acc <= acc + p.
  - All arithmetic is sign-extended to pACC_W.
  - first and last are both set only when pKERNEL_LEN=1, which is illegal.
- Stage 3, when stage-2 valid and last are set:
  - s = final acc.
  - odata <= (s<0) ? 0 : (s>65535) ? 16'hFFFF : s[15:0].
  - osat <= (s>65535).
  - ovalid <= 1 for exactly one cycle; otherwise ovalid <= 0.
  - odata and osat hold their last values while ovalid=0.
- Latency: the last sample of a window is accepted at edge N; ovalid is high in the cycle following edge N+3. This is fixed and independent of ivalid gaps.
- Throughput: one sample per clock. Back-to-back windows need no idle cycle; the first of window k+1 may follow the last of window k immediately. The first flag restarts the accumulator, so no extra clear cycle is needed.
- ivalid gaps: pipeline flags advance every clock. A cycle with ivalid=0 injects a bubble; accumulator and ocount are unchanged.
- Negative sums clamp to 0 with osat=0 (ReLU, not a saturation event).
- Reset mid-window: the partial sum is discarded, ocount returns to 0, and no ovalid is produced for the interrupted window. The first ivalid after reset deasserts is the first sample of a new window.
- No backpressure: the downstream stage always accepts odata on ovalid.

Test Plan:
- Single window: pKERNEL_LEN=9, ibias=0, idata=10, iweight=1 for 9 consecutive cycles -> one ovalid pulse 3 cycles after the 9th sample, odata=90, osat=0; ocount steps 1..8 then returns to 0.
- ReLU: idata=200, iweight=-1 ×9, ibias=100 -> odata=0, osat=0. Repeat with ibias=2000 -> odata=200, osat=0.
- Saturation: idata=255, iweight=127 ×9, ibias=32767 (sum 324232) -> odata=65535, osat=1. Then idata=255, iweight=-128 ×9, ibias=-32768 (sum -326528, no accumulator wrap) -> odata=0, osat=0.
- Gaps and back-to-back: window 1 with random ivalid gaps (all 1×1, bias 5 -> 14), immediately followed without gaps by window 2 (all 2×3, bias 0 -> 54) -> two ovalid pulses with odata 14 then 54. Bias for window 2 is sampled only on its first sample; changing ibias mid-window has no effect.
- Reset mid-window: feed 5 samples, assert irst asynchronously between edges for 2 cycles -> all outputs 0 immediately and no ovalid. Then a full window of 3×4, bias 0 -> odata=108.
- Min window: pKERNEL_LEN=2, continuous ivalid with products 1,2,3,4, bias 0 -> ovalid every 2nd cycle, odata 3 then 7.

Source files
------------

// File: rtl/conv_mac_acc16.sv
// Unsigned-by-signed MAC over one kernel window onto a bias, ReLU, unsigned 16-bit saturation.
// Result strobes 3 cycles after the window's last sample edge; no backpressure, so odata must be taken on ovalid.
module conv_mac_acc16 #(
   parameter int pKERNEL_LEN = 9,
   parameter int pCNT_W      = $clog2(pKERNEL_LEN),
   parameter int pACC_W      = 17 + $clog2(pKERNEL_LEN) + 1
) (
   input  logic              iclk,
   input  logic              irst,
   input  logic              ivalid,
   input  logic [7:0]        idata,
   input  logic [7:0]        iweight,
   input  logic [15:0]       ibias,
   output logic [15:0]       odata,
   output logic              ovalid,
   output logic              osat,
   output logic [pCNT_W-1:0] ocount
);

   localparam logic [pCNT_W-1:0] cLAST = pCNT_W'(pKERNEL_LEN - 1);

   typedef struct packed {
      logic               vld;
      logic               first;
      logic               last;
      logic signed [16:0] prod;
   } s1_t;

   s1_t                      s1;
   logic signed [pACC_W-1:0] s1_bias;
   logic signed [16:0]       prod_c;

   logic signed [pACC_W-1:0] acc;
   logic signed [pACC_W-1:0] prod_ext;
   logic signed [pACC_W-1:0] acc_nxt;
   logic                     s2_vld;
   logic                     s2_last;

   logic                     neg_c;
   logic                     big_c;
   logic [15:0]              clamp_c;
   logic                     s3_vld;
   logic [15:0]              s3_dat;
   logic                     s3_sat;

   // Activation is zero-extended so the product is a true unsigned-by-signed result.
   always_comb begin
      prod_c = $signed({{9{1'b0}}, idata}) * $signed({{9{iweight[7]}}, iweight});
   end

   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         ocount <= '0;
      end else if (ivalid) begin
         ocount <= (ocount == cLAST) ? '0 : ocount + 1'b1;
      end
   end

   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         s1      <= '0;
         s1_bias <= '0;
      end else begin
         s1.vld <= ivalid;
         if (ivalid) begin
            s1.first <= (ocount == '0);
            s1.last  <= (ocount == cLAST);
            s1.prod  <= prod_c;
            if (ocount == '0) begin
               s1_bias <= {{(pACC_W-16){ibias[15]}}, ibias};
            end
         end
      end
   end

   // The first flag reloads from the bias, so back-to-back windows need no clear cycle.
   always_comb begin
      prod_ext = {{(pACC_W-17){s1.prod[16]}}, s1.prod};
      acc_nxt  = s1.first ? (s1_bias + prod_ext) : (acc + prod_ext);
   end

   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         acc     <= '0;
         s2_vld  <= 1'b0;
         s2_last <= 1'b0;
      end else begin
         s2_vld  <= s1.vld;
         s2_last <= s1.vld & s1.last;
         if (s1.vld) begin
            acc <= acc_nxt;
         end
      end
   end

   // Negative sums are a ReLU clamp, not a saturation event.
   always_comb begin
      neg_c   = acc[pACC_W-1];
      big_c   = ~neg_c & (|acc[pACC_W-2:16]);
      clamp_c = acc[15:0];
      if (neg_c) begin
         clamp_c = 16'h0000;
      end else if (big_c) begin
         clamp_c = 16'hFFFF;
      end
   end

   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         s3_vld <= 1'b0;
         s3_dat <= '0;
         s3_sat <= 1'b0;
      end else begin
         s3_vld <= s2_vld & s2_last;
         if (s2_vld & s2_last) begin
            s3_dat <= clamp_c;
            s3_sat <= big_c;
         end
      end
   end

   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         ovalid <= 1'b0;
         odata  <= '0;
         osat   <= 1'b0;
      end else begin
         ovalid <= s3_vld;
         if (s3_vld) begin
            odata <= s3_dat;
            osat  <= s3_sat;
         end
      end
   end

endmodule

// File: tb/tb_conv_mac_acc16.sv
// Bench for conv_mac_acc16: window-sum reference model, latency, ReLU/saturation, gaps, reset, min window.
module tb_conv_mac_acc16;

   logic        iclk = 1'b0;
   logic        irst = 1'b0;
   logic        ivalid = 1'b0;
   logic [7:0]  idata = '0;
   logic [7:0]  iweight = '0;
   logic [15:0] ibias = '0;

   logic [15:0] odata, odata2;
   logic        ovalid, ovalid2, osat, osat2;
   logic [3:0]  ocount;
   logic [0:0]  ocount2;

   conv_mac_acc16 #(.pKERNEL_LEN(9)) dut (
      .iclk(iclk), .irst(irst), .ivalid(ivalid), .idata(idata), .iweight(iweight), .ibias(ibias),
      .odata(odata), .ovalid(ovalid), .osat(osat), .ocount(ocount));

   conv_mac_acc16 #(.pKERNEL_LEN(2)) dut2 (
      .iclk(iclk), .irst(irst), .ivalid(ivalid), .idata(idata), .iweight(iweight), .ibias(ibias),
      .odata(odata2), .ovalid(ovalid2), .osat(osat2), .ocount(ocount2));

   always #5 iclk = ~iclk;

   int cyc = 0;
   always @(posedge iclk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;
   int obs_dat[$], obs_sat[$], obs_cyc[$], exp_cyc[$];
   int obs2_dat[$], obs2_cyc[$];
   int wd[9], ww[9];
   int last_acc = 0;

   always @(negedge iclk) begin
      if (ovalid === 1'b1) begin
         obs_dat.push_back(int'(odata));
         obs_sat.push_back(int'(osat));
         obs_cyc.push_back(cyc);
      end
      if (ovalid2 === 1'b1) begin
         obs2_dat.push_back(int'(odata2));
         obs2_cyc.push_back(cyc);
      end
   end

   function automatic int model_sum(input int bias);
      int s = bias;
      for (int i = 0; i < 9; i++) s += wd[i] * ww[i];
      return s;
   endfunction

   function automatic int model_dat(input int s);
      if (s < 0) return 0;
      if (s > 65535) return 65535;
      return s;
   endfunction

   task automatic send_sample(input bit v, input int d, input int w, input int b);
      @(negedge iclk);
      ivalid  = v;
      idata   = 8'(d);
      iweight = 8'(w);
      ibias   = 16'(b);
      if (v) last_acc = cyc + 1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge iclk);
         ivalid = 1'b0;
      end
   endtask

   // Bias is scrambled on non-first samples: only the first sample's bias may count.
   task automatic send_window(input int bias, input bit gaps);
      for (int i = 0; i < 9; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) send_sample(0, $urandom_range(0, 255), 0, int'($urandom));
         send_sample(1, wd[i], ww[i], (i == 0) ? bias : int'($urandom));
      end
      exp_cyc.push_back(last_acc);
   endtask

   task automatic wait_outs(input int n, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 80 && !ok; k++) begin
         @(negedge iclk);
         #1;
         ok = (obs_dat.size() >= n);
      end
   endtask

   task automatic set_win(input int d, input int w);
      for (int i = 0; i < 9; i++) begin
         wd[i] = d;
         ww[i] = w;
      end
   endtask

   task automatic test_reset;
      #1 irst = 1'b1;
      #1;
      total++; if (odata !== 16'd0) begin bad++; $display("FAIL reset_odata: got %0d want 0", odata); end
      total++; if (ovalid !== 1'b0) begin bad++; $display("FAIL reset_ovalid: got %0b want 0", ovalid); end
      total++; if (osat !== 1'b0) begin bad++; $display("FAIL reset_osat: got %0b want 0", osat); end
      total++; if (ocount !== 4'd0) begin bad++; $display("FAIL reset_ocount: got %0d want 0", ocount); end
      total++; if (ocount2 !== 1'b0 || ovalid2 !== 1'b0) begin bad++; $display("FAIL reset_dut2: got %0d/%0b want 0/0", ocount2, ovalid2); end
      repeat (2) @(posedge iclk);
      @(negedge iclk) irst = 1'b0;
   endtask

   task automatic test_single_window;
      int base = obs_dat.size();
      bit ok;
      for (int i = 0; i < 9; i++) begin
         @(negedge iclk);
         if (i > 0) begin
            total++; if (ocount !== 4'(i)) begin bad++; $display("FAIL single_ocount: got %0d want %0d", ocount, i); end
         end
         ivalid = 1'b1; idata = 8'd10; iweight = 8'd1; ibias = (i == 0) ? 16'd0 : 16'($urandom);
         last_acc = cyc + 1;
      end
      exp_cyc.push_back(last_acc);
      @(negedge iclk);
      total++; if (ocount !== 4'd0) begin bad++; $display("FAIL single_ocount_wrap: got %0d want 0", ocount); end
      ivalid = 1'b0;
      wait_outs(base + 1, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL single_timeout: got %0d pulses want %0d", obs_dat.size() - base, 1); end
      else begin
         total++; if (obs_dat[base] !== 90) begin bad++; $display("FAIL single_odata: got %0d want 90", obs_dat[base]); end
         total++; if (obs_sat[base] !== 0) begin bad++; $display("FAIL single_osat: got %0d want 0", obs_sat[base]); end
         total++; if (obs_cyc[base] !== exp_cyc[base] + 3) begin bad++; $display("FAIL single_latency: got %0d want %0d", obs_cyc[base], exp_cyc[base] + 3); end
      end
      idle(6);
      total++; if (obs_dat.size() !== base + 1) begin bad++; $display("FAIL single_pulses: got %0d want 1", obs_dat.size() - base); end
   endtask

   task automatic test_relu;
      int base = obs_dat.size();
      int e[2];
      bit ok;
      set_win(200, -1);
      e[0] = model_sum(100);  send_window(100, 0);
      e[1] = model_sum(2000); send_window(2000, 0);
      idle(1);
      wait_outs(base + 2, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL relu_timeout: got %0d pulses want 2", obs_dat.size() - base); end
      else for (int k = 0; k < 2; k++) begin
         total++; if (obs_dat[base+k] !== model_dat(e[k])) begin bad++; $display("FAIL relu_odata%0d: got %0d want %0d", k, obs_dat[base+k], model_dat(e[k])); end
         total++; if (obs_sat[base+k] !== 0) begin bad++; $display("FAIL relu_osat%0d: got %0d want 0", k, obs_sat[base+k]); end
      end
   endtask

   task automatic test_saturation;
      int base = obs_dat.size();
      int e[2];
      bit ok;
      set_win(255, 127);
      e[0] = model_sum(32767);  send_window(32767, 0);
      set_win(255, -128);
      e[1] = model_sum(-32768); send_window(-32768, 0);
      idle(1);
      wait_outs(base + 2, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL sat_timeout: got %0d pulses want 2", obs_dat.size() - base); end
      else for (int k = 0; k < 2; k++) begin
         total++; if (obs_dat[base+k] !== model_dat(e[k])) begin bad++; $display("FAIL sat_odata%0d: got %0d want %0d", k, obs_dat[base+k], model_dat(e[k])); end
         total++; if (obs_sat[base+k] !== int'(e[k] > 65535)) begin bad++; $display("FAIL sat_osat%0d: got %0d want %0d", k, obs_sat[base+k], int'(e[k] > 65535)); end
      end
   endtask

   task automatic test_gaps_back_to_back;
      int base = obs_dat.size();
      int e[2];
      bit ok;
      set_win(1, 1);
      e[0] = model_sum(5); send_window(5, 1);
      set_win(2, 3);
      e[1] = model_sum(0); send_window(0, 0);
      idle(1);
      wait_outs(base + 2, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL gaps_timeout: got %0d pulses want 2", obs_dat.size() - base); end
      else for (int k = 0; k < 2; k++) begin
         total++; if (obs_dat[base+k] !== model_dat(e[k])) begin bad++; $display("FAIL gaps_odata%0d: got %0d want %0d", k, obs_dat[base+k], model_dat(e[k])); end
         total++; if (obs_cyc[base+k] !== exp_cyc[base+k] + 3) begin bad++; $display("FAIL gaps_latency%0d: got %0d want %0d", k, obs_cyc[base+k], exp_cyc[base+k] + 3); end
      end
   endtask

   task automatic test_reset_mid;
      int n0;
      int e;
      bit ok;
      for (int i = 0; i < 5; i++) send_sample(1, 7, 3, 0);
      @(posedge iclk);
      #2;
      ivalid = 1'b0;
      total++; if (ocount !== 4'd5) begin bad++; $display("FAIL mid_ocount_pre: got %0d want 5", ocount); end
      irst = 1'b1;
      #1;
      total++; if (odata !== 16'd0 || osat !== 1'b0 || ovalid !== 1'b0) begin bad++; $display("FAIL mid_outputs: got %0d/%0b/%0b want 0/0/0", odata, osat, ovalid); end
      total++; if (ocount !== 4'd0) begin bad++; $display("FAIL mid_ocount: got %0d want 0", ocount); end
      repeat (2) @(posedge iclk);
      @(negedge iclk) irst = 1'b0;
      n0 = obs_dat.size();
      idle(8);
      total++; if (obs_dat.size() !== n0) begin bad++; $display("FAIL mid_no_ovalid: got %0d pulses want 0", obs_dat.size() - n0); end
      set_win(3, 4);
      e = model_sum(0);
      send_window(0, 0);
      idle(1);
      wait_outs(n0 + 1, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL mid_timeout: got %0d pulses want 1", obs_dat.size() - n0); end
      else begin
         total++; if (obs_dat[n0] !== model_dat(e)) begin bad++; $display("FAIL mid_odata: got %0d want %0d", obs_dat[n0], model_dat(e)); end
         total++; if (obs_cyc[n0] !== exp_cyc[n0] + 3) begin bad++; $display("FAIL mid_latency: got %0d want %0d", obs_cyc[n0], exp_cyc[n0] + 3); end
      end
   endtask

   task automatic test_random;
      int base = obs_dat.size();
      int e[6];
      bit ok;
      for (int k = 0; k < 6; k++) begin
         int b;
         for (int i = 0; i < 9; i++) begin
            wd[i] = $urandom_range(0, 255);
            ww[i] = $urandom_range(0, 255) - 128;
         end
         b = $urandom_range(0, 65535) - 32768;
         e[k] = model_sum(b);
         send_window(b, k[0]);
      end
      idle(1);
      wait_outs(base + 6, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rand_timeout: got %0d pulses want 6", obs_dat.size() - base); end
      else for (int k = 0; k < 6; k++) begin
         total++; if (obs_dat[base+k] !== model_dat(e[k])) begin bad++; $display("FAIL rand_odata%0d: got %0d want %0d (sum %0d)", k, obs_dat[base+k], model_dat(e[k]), e[k]); end
         total++; if (obs_sat[base+k] !== int'(e[k] > 65535)) begin bad++; $display("FAIL rand_osat%0d: got %0d want %0d", k, obs_sat[base+k], int'(e[k] > 65535)); end
         total++; if (obs_cyc[base+k] !== exp_cyc[base+k] + 3) begin bad++; $display("FAIL rand_latency%0d: got %0d want %0d", k, obs_cyc[base+k], exp_cyc[base+k] + 3); end
      end
   endtask

   task automatic test_min_window;
      int base;
      int acc_cyc[4];
      bit ok;
      idle(6);
      irst = 1'b1;
      repeat (2) @(posedge iclk);
      @(negedge iclk) irst = 1'b0;
      base = obs2_dat.size();
      for (int i = 0; i < 4; i++) begin
         send_sample(1, i + 1, 1, 0);
         acc_cyc[i] = last_acc;
      end
      idle(1);
      ok = 1'b0;
      for (int k = 0; k < 40 && !ok; k++) begin
         @(negedge iclk);
         #1;
         ok = (obs2_dat.size() >= base + 2);
      end
      total++;
      if (!ok) begin bad++; $display("FAIL min_timeout: got %0d pulses want 2", obs2_dat.size() - base); end
      else begin
         total++; if (obs2_dat[base] !== 3) begin bad++; $display("FAIL min_odata0: got %0d want 3", obs2_dat[base]); end
         total++; if (obs2_dat[base+1] !== 7) begin bad++; $display("FAIL min_odata1: got %0d want 7", obs2_dat[base+1]); end
         total++; if (obs2_cyc[base] !== acc_cyc[1] + 3) begin bad++; $display("FAIL min_latency0: got %0d want %0d", obs2_cyc[base], acc_cyc[1] + 3); end
         total++; if (obs2_cyc[base+1] !== acc_cyc[3] + 3) begin bad++; $display("FAIL min_latency1: got %0d want %0d", obs2_cyc[base+1], acc_cyc[3] + 3); end
      end
      total++; if (ocount2 !== 1'b0) begin bad++; $display("FAIL min_ocount: got %0d want 0", ocount2); end
   endtask

   initial begin
      test_reset();
      test_single_window();
      test_relu();
      test_saturation();
      test_gaps_back_to_back();
      test_reset_mid();
      test_random();
      test_min_window();
      idle(4);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
